// File: rtl/rv32_pkg.sv
// rv32_pkg: RV32I opcode constants, NOP encoding and the decoded-field bundle shared by the encoder.
package rv32_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [31:0] NOP = 32'h00000013;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } fields_t;

endpackage

// File: rtl/imm_packer.sv
// imm_packer: combinational RV32I field packer; INSTR_ENCODER_RANGE_CHECK_EN adds immediate range/alignment flags.
module imm_packer
    import rv32_pkg::*;
(
    input  fields_t     i_fields,
    output logic [31:0] o_instr,
    output logic        o_err
);

    logic [6:0]  w_op;
    logic [2:0]  w_f3;
    logic [31:0] w_imm;
    logic        w_shift;
    logic        w_known;
    logic        w_rng;

    assign w_op    = i_fields.opcode;
    assign w_f3    = i_fields.funct3;
    assign w_imm   = i_fields.imm;
    assign w_shift = (w_f3 == 3'b001) || (w_f3 == 3'b101);

    // Place immediate slices into the format chosen by the opcode; unknown opcodes become a flagged NOP.
    always_comb begin
        o_instr = NOP;
        w_known = 1'b1;
        case (w_op)
            OPC_JAL:
                o_instr = {w_imm[20], w_imm[10:1], w_imm[11], w_imm[19:12], i_fields.rd, w_op};
            OPC_LUI, OPC_AUIPC:
                o_instr = {w_imm[31:12], i_fields.rd, w_op};
            OPC_OP_IMM:
                o_instr = w_shift ? {i_fields.funct7, w_imm[4:0], i_fields.rs1, w_f3, i_fields.rd, w_op}
                                  : {w_imm[11:0], i_fields.rs1, w_f3, i_fields.rd, w_op};
            OPC_LOAD, OPC_JALR, OPC_SYSTEM:
                o_instr = {w_imm[11:0], i_fields.rs1, w_f3, i_fields.rd, w_op};
            OPC_BRANCH:
                o_instr = {w_imm[12], w_imm[10:5], i_fields.rs2, i_fields.rs1, w_f3, w_imm[4:1], w_imm[11], w_op};
            OPC_STORE:
                o_instr = {w_imm[11:5], i_fields.rs2, i_fields.rs1, w_f3, w_imm[4:0], w_op};
            OPC_OP:
                o_instr = {i_fields.funct7, i_fields.rs2, i_fields.rs1, w_f3, i_fields.rd, w_op};
            default:
                w_known = 1'b0;
        endcase
    end

`ifdef INSTR_ENCODER_RANGE_CHECK_EN
    logic w_sext12;
    logic w_sext13;
    logic w_sext21;

    assign w_sext12 = (w_imm[31:11] == '0) || (w_imm[31:11] == '1);
    assign w_sext13 = (w_imm[31:12] == '0) || (w_imm[31:12] == '1);
    assign w_sext21 = (w_imm[31:20] == '0) || (w_imm[31:20] == '1);

    // Flag immediates that do not survive truncation into their field, or are misaligned.
    always_comb begin
        w_rng = 1'b0;
        case (w_op)
            OPC_OP_IMM:
                w_rng = w_shift ? |w_imm[31:5] : (w_f3 == 3'b011) ? |w_imm[31:12] : !w_sext12;
            OPC_LOAD, OPC_JALR, OPC_STORE:
                w_rng = !w_sext12;
            OPC_SYSTEM:
                w_rng = |w_imm[31:12];
            OPC_BRANCH:
                w_rng = !w_sext13 || w_imm[0];
            OPC_JAL:
                w_rng = !w_sext21 || w_imm[0];
            OPC_LUI, OPC_AUIPC:
                w_rng = |w_imm[11:0];
            default:
                w_rng = 1'b0;
        endcase
    end
`else
    assign w_rng = 1'b0;
`endif

    assign o_err = !w_known || w_rng;

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: 2-stage elastic RV32I encoder (S1 fields, S2 packed word) with delivery counter; see INSTR_ENCODER_RANGE_CHECK_EN.
module instr_encoder
    import rv32_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  in_opcode,
    input  logic [2:0]  in_funct3,
    input  logic [6:0]  in_funct7,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_err,
    output logic [15:0] enc_count
);

    fields_t     r_s1;
    logic        r_s1_full;
    logic        r_s2_full;
    logic [31:0] r_s2_instr;
    logic        r_s2_err;
    logic [15:0] r_count;
    logic [31:0] w_instr;
    logic        w_err;
    logic        w_s1_adv;
    logic        w_acc;
    logic        w_del;

    assign w_s1_adv = r_s1_full && (!r_s2_full || out_ready);
    assign in_ready = resetn && (!r_s1_full || !r_s2_full || out_ready);
    assign w_acc    = in_valid && in_ready;
    assign w_del    = r_s2_full && out_ready;

    imm_packer u_packer (
        .i_fields (r_s1),
        .o_instr  (w_instr),
        .o_err    (w_err)
    );

    // S1 captures accepted fields and empties when its word moves on to S2.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_s1      <= '0;
            r_s1_full <= 1'b0;
        end else begin
            r_s1_full <= w_acc || (r_s1_full && !w_s1_adv);
            if (w_acc)
                r_s1 <= '{in_opcode, in_funct3, in_funct7, in_rd, in_rs1, in_rs2, in_imm};
        end
    end

    // S2 holds the packed word steady until the sink takes it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_s2_full  <= 1'b0;
            r_s2_instr <= '0;
            r_s2_err   <= 1'b0;
        end else begin
            r_s2_full <= w_s1_adv || (r_s2_full && !out_ready);
            if (w_s1_adv) begin
                r_s2_instr <= w_instr;
                r_s2_err   <= w_err;
            end
        end
    end

    // Count delivered words, wrapping naturally at 16 bits.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            r_count <= '0;
        else if (w_del)
            r_count <= r_count + 16'd1;
    end

    assign out_valid = r_s2_full;
    assign out_instr = r_s2_instr;
    assign out_err   = r_s2_err;
    assign enc_count = r_count;

endmodule
